// File: rtl/s_axis_cc_arbiter_pkg.sv
// Shared definitions for the completer-completion (CC) stream arbiters.
// Optional build macro: LITEPCIE_CC_ARB_PRIO0_EN (port 0 strict priority).
package litepcie_cc_pkg;

  localparam int MAX_PORTS         = 8;
  localparam int TUSER_WIDTH       = 4;
  localparam int TUSER_TD          = 0;
  localparam int TUSER_DISCONTINUE = 3;

  // IDLE: choosing the next owner. LOCKED: forwarding the owner's packet.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } cc_state_e;

  // Index reached by stepping 'step' positions after 'ptr' in a ring of n.
  function automatic int rr_next(input int ptr, input int step, input int n);
    return (ptr + step) % n;
  endfunction

endpackage

// File: rtl/s_axis_cc_arbiter_if.sv
// Bundle of the per-source CC streams and the single stream to the adapter.
//
// Handshake: on every stream a beat moves on a rising clock edge where
// tvalid and tready are both high. A source holding tvalid high keeps its
// beat stable until it is taken; tready may change freely.
interface s_axis_cc_arbiter_if #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_PORTS  = 2
);
  import litepcie_cc_pkg::*;

  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_tkeep;
  logic [NUM_PORTS-1:0]             s_tlast;
  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_tuser;
  logic [NUM_PORTS-1:0]             s_tvalid;
  logic [NUM_PORTS-1:0]             s_tready;

  logic [DATA_WIDTH-1:0]            m_tdata;
  logic [KEEP_WIDTH-1:0]            m_tkeep;
  logic                             m_tlast;
  logic [TUSER_WIDTH-1:0]           m_tuser;
  logic                             m_tvalid;
  logic                             m_tready;

  // Arbiter side: consumes the sources, drives the adapter.
  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tuser, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid
  );

  // Environment side: the completion sources plus the adapter.
  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tuser, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid
  );

endinterface

// File: rtl/s_axis_cc_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after rr_ptr_i, wrapping.
// Shared with the RC/RQ arbiters.
module rr_select
  import litepcie_cc_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // Walk rr_ptr_i+1 .. rr_ptr_i+N and keep the first requesting index.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'(rr_next(int'(rr_ptr_i), k, N));
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s_axis_cc_arbiter.sv
// Packet-level round-robin arbiter in front of the CC adapter.
// One source owns the output from grant until its tlast beat; the output
// stage is a single register slice (no combinational m_tready->m_tvalid path).
// Build macro LITEPCIE_CC_ARB_PRIO0_EN: port 0 wins every arbitration it
// requests, the other ports rotate among themselves.
module s_axis_cc_arbiter
  import litepcie_cc_pkg::*;
#(
  parameter  int DATA_WIDTH = 128,
  parameter  int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter  int NUM_PORTS  = 2,
  localparam int IW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  s_axis_cc_arbiter_if.slave    bus,
  output logic [NUM_PORTS-1:0]  grant,
  output logic                  busy,
  output cc_state_e             dbg_state,
  output logic [IW-1:0]         dbg_rr_ptr
);

  cc_state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]     grant_q, grant_d;
  logic [IW-1:0]            gidx_q, gidx_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;

  logic [DATA_WIDTH-1:0]    m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0]    m_tkeep_q, m_tkeep_d;
  logic [TUSER_WIDTH-1:0]   m_tuser_q, m_tuser_d;
  logic                     m_tlast_q, m_tlast_d;
  logic                     m_tvalid_q, m_tvalid_d;

  logic [DATA_WIDTH-1:0]    sel_data;
  logic [KEEP_WIDTH-1:0]    sel_keep;
  logic [TUSER_WIDTH-1:0]   sel_user;
  logic                     sel_valid, sel_last;
  logic                     load_en, accept;

  logic                     prio_hit, rr_upd;
  logic [NUM_PORTS-1:0]     pick_req, pick_gnt;
  logic [IW-1:0]            pick_idx;
  logic                     pick_any;

`ifdef LITEPCIE_CC_ARB_PRIO0_EN
  // Port 0 bypasses the rotation and never moves the pointer.
  assign prio_hit = bus.s_tvalid[0];
  assign pick_req = {bus.s_tvalid[NUM_PORTS-1:1], 1'b0};
  assign rr_upd   = (gidx_q != '0);
`else
  assign prio_hit = 1'b0;
  assign pick_req = bus.s_tvalid;
  assign rr_upd   = 1'b1;
`endif

  rr_select #(.N(NUM_PORTS)) u_rr_select (
    .req_i    (pick_req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_gnt),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // The output slot can take a beat when empty or being drained this cycle.
  assign load_en   = !m_tvalid_q || bus.m_tready;
  assign sel_valid = |(bus.s_tvalid & grant_q);
  assign sel_last  = |(bus.s_tlast & grant_q);
  assign accept    = (state_q == LOCKED) && sel_valid && load_en;
  assign bus.s_tready = (state_q == LOCKED) ? (grant_q & {NUM_PORTS{load_en}}) : '0;

  // AND-OR mux of the owner's payload, steered by the one-hot grant.
  always_comb begin
    sel_data = '0;
    sel_keep = '0;
    sel_user = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        sel_data = sel_data | bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep = sel_keep | bus.s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user = sel_user | bus.s_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
      end
    end
  end

  // Arbitration FSM: pick an owner in IDLE, release it after its tlast beat.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (prio_hit) begin
          grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1};
          gidx_d  = '0;
          state_d = LOCKED;
        end else if (pick_any) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          grant_d = '0;
          state_d = IDLE;
          if (rr_upd) rr_ptr_d = gidx_q;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output slice: load the accepted beat, or empty the slot when nothing came.
  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    if (load_en) begin
      m_tvalid_d = accept;
      if (accept) begin
        m_tdata_d = sel_data;
        m_tkeep_d = sel_keep;
        m_tuser_d = sel_user;
        m_tlast_d = sel_last;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= IW'(NUM_PORTS - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output stage registers; reset drops any partial packet immediately.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
    end else begin
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tkeep  = m_tkeep_q;
  assign bus.m_tuser  = m_tuser_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign grant        = grant_q;
  assign busy         = (state_q == LOCKED) || m_tvalid_q;
  assign dbg_state    = state_q;
  assign dbg_rr_ptr   = rr_ptr_q;

endmodule

// File: doc/s_axis_cc_arbiter.md
Name: s_axis_cc_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single completer-completion (CC) AXI-Stream input of the CC adapter among NUM_PORTS completion sources, e.g. the MMAP slave and the MSI/config responders.
- Grants one source per packet, holds the grant until that source's tlast beat, then re-arbitrates.
- Drives the adapter through a registered output stage.
- Sits in the user_clk domain, directly upstream of the CC adapter.

Parameters:
- DATA_WIDTH, 128, beat width in bits (128/256/512).
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- NUM_PORTS, 2, number of requesters (2..8).

Ports:
- user_clk  in  1  clock.
- user_reset_n  in  1  asynchronous active-low reset.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data; port i occupies slice i.
- s_tkeep  in  NUM_PORTS*KEEP_WIDTH  per-port byte enables.
- s_tlast  in  NUM_PORTS  per-port end of packet.
- s_tuser  in  NUM_PORTS*4  per-port sideband (bit0 TD, bit3 discontinue).
- s_tvalid  in  NUM_PORTS  per-port valid.
- s_tready  out  NUM_PORTS  per-port ready.
- m_tdata  out  DATA_WIDTH  to adapter.
- m_tkeep  out  KEEP_WIDTH  to adapter.
- m_tlast  out  1  to adapter.
- m_tuser  out  4  to adapter.
- m_tvalid  out  1  to adapter.
- m_tready  in  1  from adapter.
- grant  out  NUM_PORTS  one-hot current owner; all zero when idle.
- busy  out  1  a packet is in progress.

Behaviour:
- Reset: state IDLE; grant=0; busy=0; m_tvalid=0; m_tlast=0; m_tdata/m_tkeep/m_tuser=0; s_tready=0; rr_ptr=NUM_PORTS-1 (last-served index).
- FSM IDLE:
  - If any s_tvalid, select the first asserted index searching rr_ptr+1, rr_ptr+2, … modulo NUM_PORTS.
  - Register the one-hot grant; go to LOCKED next cycle.
  - s_tready is 0 in IDLE.
  - Cost: one bubble cycle per packet.
- FSM LOCKED:
  - s_tready[g] = load_en, where load_en = !m_tvalid || m_tready; other ports' s_tready = 0.
  - On s_tvalid[g] && s_tready[g]: capture port g's tdata/tkeep/tlast/tuser into the output register; m_tvalid=1.
  - Output register on load_en without a source beat: m_tvalid=0.
  - Latency from source accept to m_tvalid: 1 cycle. Full throughput within a packet; no combinational ready path from m_tready to m_tvalid.
- Packet end: on an accepted beat with s_tlast[g]=1, set rr_ptr=g, grant=0, return to IDLE. That same cycle's last beat is still loaded.
- Source deasserts tvalid mid-packet: the grant is held indefinitely; no timeout. Other ports stall.
- Adapter backpressure: m_tready=0 with m_tvalid=1 holds the output register stable and drops s_tready.
- Single-beat packet (tvalid+tlast together): IDLE→LOCKED→IDLE, 2 cycles per packet minimum.
- Fairness: with all ports continuously valid, grants rotate 0,1,…,N-1,0. No port waits more than N-1 packets.
- A port's tvalid arriving while another port is LOCKED is ignored until IDLE.
- Asynchronous reset mid-packet: all state cleared immediately; the partial packet is dropped; m_tvalid deasserts asynchronously.
- busy = (state==LOCKED) || m_tvalid.

Optional Feature:
- Macro: LITEPCIE_CC_ARB_PRIO0_EN.
- Defined: port 0 has strict priority in IDLE. If s_tvalid[0]=1, grant port 0 regardless of rr_ptr; otherwise apply round-robin among ports 1..N-1. rr_ptr is not updated by port-0 packets. A locked packet on another port is never preempted.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package litepcie_cc_pkg:
  - state enum (IDLE, LOCKED).
  - localparams for tuser bit positions (TUSER_TD=0, TUSER_DISCONTINUE=3).
  - MAX_PORTS=8.
- One sub-module, rr_select: a combinational round-robin picker taking req[N] and rr_ptr, returning a one-hot grant and an index. It is also used by the future RC/RQ arbiters.

Test Plan:
- Both ports valid, each with a 3-beat packet (port 0 data 0xA0..A2, port 1 data 0xB0..B2), m_tready=1 → m_tdata sequence A0,A1,A2,B0,B1,B2; grant 01→10; one idle cycle between packets.
- Port 1 only, 1-beat packet with tuser=4'b1000 → m_tvalid one cycle later, m_tuser=4'b1000, m_tlast=1; rr_ptr=1.
- Port 0 mid-packet; m_tready toggles 1,0,0,1 → m_tdata held constant while stalled; no beat lost or duplicated; s_tready[0] low during the stall.
- user_reset_n pulsed low during beat 2 of a 4-beat packet → m_tvalid=0 and grant=0 immediately; next packet starts clean from port 0.
- 100 back-to-back packets, all ports valid, NUM_PORTS=4 → grant counts per port 25 each; with LITEPCIE_CC_ARB_PRIO0_EN, port 0 wins every IDLE in which it is valid.
